// File: rtl/div_sign_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_sign_ctrl_pkg
// Purpose  : Shared types, constants and helpers for the divider sign front end
// Revision : 1.0 - initial release
// ============================================================================
package div_sign_ctrl_pkg;

    // Widest operand the helpers support; callers zero-extend into it and slice back.
    localparam int DIV_MAX_W = 64;

    localparam logic [DIV_MAX_W-1:0] DIV_DBZ_Q = {DIV_MAX_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_FIX  = 3'd3,
        ST_RESP = 3'd4
    } div_state_t;

    // Modulo-2^N negate; the low bits of a wide negate equal the narrow negate.
    function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                      input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_sign_ctrl
// Purpose  : Signed/unsigned request front end for the unsigned iterative divider
// Revision : 1.0 - initial release
// ============================================================================
module div_sign_ctrl
    import div_sign_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_rst,
    output logic             core_ena,
    input  logic [WIDTH-1:0] core_q,
    input  logic [WIDTH-1:0] core_r,
    input  logic             core_dne
);

    localparam logic [WIDTH-1:0] c_min   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_dbz_q = DIV_DBZ_Q[WIDTH-1:0];

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic r_sign_a;
    logic r_sign_b;
    logic w_accept;
    logic w_retire;
    logic w_sign_a;
    logic w_sign_b;
    logic w_dbz;
    logic w_ovf;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return WIDTH'(cond_neg(DIV_MAX_W'(v), en));
    endfunction

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_RESP) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_retire  = rsp_valid && rsp_ready;

    assign w_sign_a  = req_signed & req_a[WIDTH-1];
    assign w_sign_b  = req_signed & req_b[WIDTH-1];
    assign w_dbz     = (req_b == '0);
    assign w_ovf     = req_signed && (req_a == c_min) && (req_b == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        core_rst    = 1'b0;
        core_ena    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_dbz || w_ovf) ? ST_RESP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_rst    = 1'b1;
                core_ena    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                core_ena = 1'b1;
                if (core_dne) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_retire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // The core is frozen as soon as reset is seen, not one edge later.
        if (rst) begin
            core_rst = 1'b0;
            core_ena = 1'b0;
        end
    end

    // Raw core results park in the response registers and are sign-fixed in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q    <= '0;
            rsp_r    <= '0;
            rsp_dbz  <= 1'b0;
            core_a   <= '0;
            core_b   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        if (w_dbz) begin
                            rsp_q   <= c_dbz_q;
                            rsp_r   <= req_a;
                            rsp_dbz <= 1'b1;
                        end else if (w_ovf) begin
                            rsp_q   <= c_min;
                            rsp_r   <= '0;
                            rsp_dbz <= 1'b0;
                        end else begin
                            core_a  <= neg_w(req_a, w_sign_a);
                            core_b  <= neg_w(req_b, w_sign_b);
                            rsp_dbz <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (core_dne) begin
                        rsp_q <= core_q;
                        rsp_r <= core_r;
                    end
                end
                ST_FIX: begin
                    rsp_q   <= neg_w(rsp_q, r_sign_a ^ r_sign_b);
                    rsp_r   <= neg_w(rsp_r, r_sign_a);
                    rsp_dbz <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sign_ctrl
// Purpose  : Scoreboard bench for div_sign_ctrl with a behavioural divider core
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sign_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_signed = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dbz;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_rst;
    logic         core_ena;
    logic [W-1:0] core_q = '0;
    logic [W-1:0] core_r = '0;
    logic         core_dne = 1'b0;

    int   checks = 0;
    int   failures = 0;
    int   core_lat = 3;
    int   load_pulses = 0;
    int   ena_cycles = 0;
    rsp_t sb[$];

    always #5 clk = ~clk;

    div_sign_ctrl #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_r      (rsp_r),
        .rsp_dbz    (rsp_dbz),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_rst   (core_rst),
        .core_ena   (core_ena),
        .core_q     (core_q),
        .core_r     (core_r),
        .core_dne   (core_dne)
    );

    // Behavioural unsigned divider: done is a level, cleared by the load edge.
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = 32'd1;
    int           m_cnt = 0;
    always @(posedge clk) begin
        if (core_ena) begin
            if (core_rst) begin
                m_a      <= core_a;
                m_b      <= core_b;
                m_cnt    <= core_lat;
                core_dne <= 1'b0;
            end else if (!core_dne) begin
                if (m_cnt <= 1) begin
                    core_dne <= 1'b1;
                    core_q   <= m_a / m_b;
                    core_r   <= m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        rsp_t             e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb_v;
        sa   = a;
        sb_v = b;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = '0; e.dbz = 1'b0;
        end else if (s) begin
            e.q = sa / sb_v; e.r = sa % sb_v; e.dbz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (core_rst) load_pulses++;
        if (core_ena) ena_cycles++;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("rsp_q", rsp_q, e.q);
                check_val("rsp_r", rsp_r, e.r);
                check_val("rsp_dbz", rsp_dbz, e.dbz);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit exp_rsp);
        bit ok = 0;
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
        if (exp_rsp) sb.push_back(model(a, b, s));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check_val("rsp_timeout", sb.size(), 64'd0);
            sb.delete();
        end
        #1;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lp0;
        int en0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        @(negedge clk);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_core_ena", core_ena, 0);
        check_val("rst_core_rst", core_rst, 0);
        check_val("rst_rsp_q", rsp_q, 0);
        check_val("rst_rsp_r", rsp_r, 0);
        check_val("rst_rsp_dbz", rsp_dbz, 0);
        check_val("rst_core_ab", {core_a, core_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("idle_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Unsigned 100/7 with a single-cycle load pulse
        lp0 = load_pulses;
        send(100, 7, 1'b0, 1'b1);
        @(negedge clk);
        check_val("load_core_rst", core_rst, 1);
        check_val("load_core_ena", core_ena, 1);
        check_val("load_core_a", core_a, 100);
        check_val("load_core_b", core_b, 7);
        @(negedge clk);
        check_val("wait_core_rst", core_rst, 0);
        check_val("wait_core_ena", core_ena, 1);
        drain();
        check_val("load_pulse_count", load_pulses - lp0, 1);

        // Signed operands reach the core as magnitudes
        send(32'hFFFF_FF9C, 7, 1'b1, 1'b1);
        @(negedge clk);
        check_val("neg_a_core_a", core_a, 100);
        drain();
        send(100, 32'hFFFF_FFF9, 1'b1, 1'b1);
        @(negedge clk);
        check_val("neg_b_core_b", core_b, 7);
        drain();

        // Divide by zero, both signednesses
        for (int s = 0; s < 2; s++) begin
            lp0 = load_pulses;
            en0 = ena_cycles;
            send(5, 0, s[0], 1'b1);
            @(negedge clk);
            check_val("dbz_latency", rsp_valid, 1);
            drain();
            check_val("dbz_no_load", load_pulses - lp0, 0);
            check_val("dbz_no_ena", ena_cycles - en0, 0);
        end

        // MIN / -1 signed short-circuits; unsigned goes through the core
        lp0 = load_pulses;
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk);
        check_val("ovf_latency", rsp_valid, 1);
        drain();
        check_val("ovf_no_load", load_pulses - lp0, 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        check_val("ovf_u_load", core_rst, 1);
        drain();

        // Backpressure: response held, requests ignored
        rsp_ready = 1'b0;
        send(1000, 3, 1'b0, 1'b1);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 req_valid = 1'b1; req_a = 9; req_b = 2; req_signed = 1'b0;
            @(negedge clk);
            check_val("bp_valid", rsp_valid, 1);
            check_val("bp_q", rsp_q, 333);
            check_val("bp_r", rsp_r, 1);
            check_val("bp_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0; rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check_val("bp_ready_after", req_ready, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a core wait drops the transaction
        core_lat = 20;
        send(32'h1234, 5, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("midwait_ena", core_ena, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ena", core_ena, 0);
        check_val("post_rst_valid", rsp_valid, 0);
        check_val("post_rst_idle", req_ready, 1);
        @(posedge clk);
        #1 core_lat = 5;
        send(32'hFFFF_FFFF, 16, 1'b0, 1'b1);
        drain();

        // Random mix of signedness, divisors and core latencies
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case (n % 4)
                0:       rb = $urandom_range(1, 15);
                1:       rb = $urandom;
                2:       rb = -($urandom_range(1, 300));
                default: rb = (n % 8 == 3) ? 32'd0 : $urandom_range(1, 1000);
            endcase
            core_lat = $urandom_range(1, 6);
            send(ra, rb, n[0] ^ n[2], 1'b1);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
